// File: rtl/clock_pkg.sv
// Shared mode encodings, BCD limits and the two-digit BCD increment used by the time chain.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  // Next BCD value: max wraps to min, a ones digit of 9 carries into tens.
  function automatic logic [7:0] bcd_next(input logic [7:0] v,
                                          input logic [7:0] max_v,
                                          input logic [7:0] min_v);
    if (v == max_v) return min_v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN..MAX; carry_c flags an increment that wraps.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_59,
  parameter logic [7:0] MIN = BCD_00,
  parameter logic [7:0] RST = MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry_c
);

  assign carry_c = inc & (value == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RST;
    end else if (clr) begin
      value <= RST;
    end else if (inc) begin
      value <= bcd_next(value, MAX, MIN);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss keeper driven by the divider's tick level, with a button set mode.
// Define HOUR12_EN for 12-hour counting with a PM flag.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       sec_pulse,
  output logic       pm
);

  localparam int unsigned PRE_W = 10;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

`ifdef HOUR12_EN
  localparam logic [7:0] HR_MAX = BCD_12;
  localparam logic [7:0] HR_MIN = BCD_01;
  localparam logic [7:0] HR_RST = BCD_12;
`else
  localparam logic [7:0] HR_MAX = BCD_23;
  localparam logic [7:0] HR_MIN = BCD_00;
  localparam logic [7:0] HR_RST = BCD_00;
`endif

  mode_e            state;
  logic             tick_prev;
  logic [PRE_W-1:0] presc;

  logic run_c, tick_edge_c, sec_event_c;
  logic sec_inc_c, min_inc_c, hr_inc_c, sec_clr_c;
  logic sec_carry_c, min_carry_c, day_wrap_unused;

  assign run_c       = (state == MODE_RUN);
  assign tick_edge_c = tick_in & ~tick_prev;
  assign sec_event_c = run_c & tick_edge_c & (presc == PRE_LAST);

  // Set-mode increments never carry; a simultaneous mode press drops the increment.
  assign sec_inc_c = sec_event_c;
  assign min_inc_c = (run_c & sec_carry_c) |
                     ((state == MODE_SET_MIN) & btn_inc & ~btn_mode);
  assign hr_inc_c  = (run_c & min_carry_c) |
                     ((state == MODE_SET_HR) & btn_inc & ~btn_mode);
  assign sec_clr_c = (state == MODE_SET_MIN) & btn_mode;

  bcd_mod_counter #(.MAX(BCD_59), .MIN(BCD_00), .RST(BCD_00)) u_sec (
    .clk(clk), .reset(reset), .clr(sec_clr_c), .inc(sec_inc_c),
    .value(sec_bcd), .carry_c(sec_carry_c)
  );

  bcd_mod_counter #(.MAX(BCD_59), .MIN(BCD_00), .RST(BCD_00)) u_min (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(min_inc_c),
    .value(min_bcd), .carry_c(min_carry_c)
  );

  bcd_mod_counter #(.MAX(HR_MAX), .MIN(HR_MIN), .RST(HR_RST)) u_hour (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(hr_inc_c),
    .value(hour_bcd), .carry_c(day_wrap_unused)
  );

  // Edge detect, prescaler, second pulse and mode FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_prev <= 1'b0;
      presc     <= '0;
      sec_pulse <= 1'b0;
      state     <= MODE_RUN;
    end else begin
      tick_prev <= tick_in;
      sec_pulse <= sec_event_c;
      if (!run_c) begin
        presc <= '0;
      end else if (tick_edge_c) begin
        presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
      end
      if (btn_mode) begin
        case (state)
          MODE_RUN:     state <= MODE_SET_HR;
          MODE_SET_HR:  state <= MODE_SET_MIN;
          MODE_SET_MIN: state <= MODE_RUN;
          default:      state <= MODE_RUN;
        endcase
      end
    end
  end

  assign mode = state;

`ifdef HOUR12_EN
  // PM flips whenever the hour steps 11 -> 12, in RUN or SET_HR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm <= 1'b0;
    end else if (hr_inc_c && (hour_bcd == BCD_11)) begin
      pm <= ~pm;
    end
  end
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench: two time_keeper instances (1 and 4 ticks/s) against a wall-clock style model.
module tb_time_keeper;

  logic clk = 1'b0;
  logic reset, tick_in, btn_mode, btn_inc;
  logic [7:0] h1, m1, s1, h4, m4, s4;
  logic [1:0] md1, md4;
  logic sp1, sp4, pm1, pm4;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

`ifdef HOUR12_EN
  localparam int RST_H = 12;
  localparam int PRE_H = 11;
  localparam logic [7:0] WRAP_H = 8'h12;
  localparam logic WRAP_PM = 1'b1;
`else
  localparam int RST_H = 0;
  localparam int PRE_H = 23;
  localparam logic [7:0] WRAP_H = 8'h00;
  localparam logic WRAP_PM = 1'b0;
`endif

  // Model state: index 0 is the 1 tick/s instance, index 1 the 4 ticks/s one.
  int hh[2], mm[2], ss[2], pre[2], pmf[2], pulse[2];
  int tps[2] = '{1, 4};
  int md;
  bit prev_tick;

  always #5 clk = ~clk;

  time_keeper #(.TICKS_PER_SEC(1)) u_dut1 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_bcd(h1), .min_bcd(m1), .sec_bcd(s1), .mode(md1), .sec_pulse(sp1), .pm(pm1)
  );

  time_keeper #(.TICKS_PER_SEC(4)) u_dut4 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_bcd(h4), .min_bcd(m4), .sec_bcd(s4), .mode(md4), .sec_pulse(sp4), .pm(pm4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic void hour_adv(input int i);
`ifdef HOUR12_EN
    if (hh[i] == 11) begin
      hh[i] = 12;
      pmf[i] = pmf[i] ^ 1;
    end else if (hh[i] == 12) begin
      hh[i] = 1;
    end else begin
      hh[i] = hh[i] + 1;
    end
`else
    hh[i] = (hh[i] + 1) % 24;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      hh[i] = RST_H; mm[i] = 0; ss[i] = 0; pre[i] = 0; pmf[i] = 0; pulse[i] = 0;
    end
    md = 0;
    prev_tick = 1'b0;
  endfunction

  // One clock of the model: inputs t/bm/bi as seen at this edge.
  function automatic void model_step(input logic t, input logic bm, input logic bi);
    bit tedge;
    tedge = t && !prev_tick;
    prev_tick = t;
    for (int i = 0; i < 2; i++) begin
      pulse[i] = 0;
      if (md == 0) begin
        if (tedge) begin
          pre[i] = pre[i] + 1;
          if (pre[i] == tps[i]) begin
            pre[i] = 0;
            pulse[i] = 1;
            ss[i] = ss[i] + 1;
            if (ss[i] == 60) begin
              ss[i] = 0;
              mm[i] = mm[i] + 1;
              if (mm[i] == 60) begin
                mm[i] = 0;
                hour_adv(i);
              end
            end
          end
        end
      end else begin
        pre[i] = 0;
        if (!bm && bi) begin
          if (md == 1) hour_adv(i);
          else mm[i] = (mm[i] + 1) % 60;
        end
        if (md == 2 && bm) ss[i] = 0;
      end
    end
    if (bm) md = (md + 1) % 3;
  endfunction

  task automatic compare_all();
    check("hour1", 32'(h1), to_bcd(hh[0]));
    check("min1", 32'(m1), to_bcd(mm[0]));
    check("sec1", 32'(s1), to_bcd(ss[0]));
    check("mode1", 32'(md1), 32'(md));
    check("pulse1", 32'(sp1), 32'(pulse[0]));
    check("pm1", 32'(pm1), 32'(pmf[0]));
    check("hour4", 32'(h4), to_bcd(hh[1]));
    check("min4", 32'(m4), to_bcd(mm[1]));
    check("sec4", 32'(s4), to_bcd(ss[1]));
    check("mode4", 32'(md4), 32'(md));
    check("pulse4", 32'(sp4), 32'(pulse[1]));
    check("pm4", 32'(pm4), 32'(pmf[1]));
  endtask

  task automatic step(input logic t, input logic bm, input logic bi);
    tick_in = t; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(t, bm, bi);
    #1;
    if (sp1) pulse_cnt++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_mode();
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_hour(input int target);
    for (int k = 0; k < 30 && hh[0] != target; k++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_min(input int target);
    for (int k = 0; k < 70 && mm[0] != target; k++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all();
    check("rst_hour", 32'(h1), to_bcd(RST_H));
    check("rst_mode", 32'(md1), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int lvl, hold;
    logic bm, bi;
    reset = 1'b1; tick_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    #1 model_reset();
    compare_all();
    // Reset held while the tick keeps toggling.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    check("rst_sec", 32'(s1), 32'h00);
    reset = 1'b0;

    // One minute of ticks at 1 tick/s.
    pulse_cnt = 0;
    ticks(60);
    check("min_after60", 32'(m1), 32'h01);
    check("sec_after60", 32'(s1), 32'h00);
    check("pulses60", 32'(pulse_cnt), 32'd60);

    // Preload 23:59:58 (11:59:58 in 12-hour), then cross the day boundary.
    press_mode();
    set_hour(PRE_H);
    press_mode();
    set_min(59);
    press_mode();
    ticks(58);
    check("pre_hour", 32'(h1), to_bcd(PRE_H));
    check("pre_sec", 32'(s1), 32'h58);
    step(1'b1, 1'b0, 1'b0);
    check("to_59", 32'(s1), 32'h59);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("wrap_hour", 32'(h1), 32'(WRAP_H));
    check("wrap_min", 32'(m1), 32'h00);
    check("wrap_sec", 32'(s1), 32'h00);
    check("wrap_pm", 32'(pm1), 32'(WRAP_PM));
    step(1'b0, 1'b0, 1'b0);

    // Prescaler of 4: 7 edges give one second, the 8th gives two.
    async_reset();
    ticks(7);
    check("tps4_7", 32'(s4), 32'h01);
    ticks(1);
    check("tps4_8", 32'(s4), 32'h02);
    for (int k = 0; k < 100; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    ticks(3);
    check("tps4_hold", 32'(s4), 32'h03);

    // Set mode: hours, ticks ignored, minutes, exit clears seconds.
    async_reset();
    ticks(5);
    press_mode();
    check("set_hr_mode", 32'(md1), 32'd1);
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    check("set_hr25", 32'(h1), 32'h01);
    check("set_hr_min", 32'(m1), 32'h00);
    check("set_ignore_tick", 32'(s1), 32'h05);
    press_mode();
    for (int k = 0; k < 61; k++) step(1'b0, 1'b0, 1'b1);
    check("set_min61", 32'(m1), 32'h01);
    press_mode();
    check("exit_mode", 32'(md1), 32'd0);
    check("exit_sec", 32'(s1), 32'h00);

    // Simultaneous mode+inc in RUN, then mode+second in RUN.
    step(1'b0, 1'b1, 1'b1);
    check("mode_inc_mode", 32'(md1), 32'd1);
    check("mode_inc_hour", 32'(h1), 32'h01);
    press_mode();
    press_mode();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mode_sec_sec", 32'(s1), 32'h01);
    check("mode_sec_mode", 32'(md1), 32'd1);
    press_mode();
    press_mode();

    // Reset mid-count at 12:34:56.
    press_mode();
    set_hour(12);
    press_mode();
    set_min(34);
    press_mode();
    ticks(56);
    check("mid_hour", 32'(h1), 32'h12);
    check("mid_min", 32'(m1), 32'h34);
    check("mid_sec", 32'(s1), 32'h56);
    async_reset();

    // Random mix of ticks and buttons.
    lvl = 0;
    hold = 1;
    for (int k = 0; k < 3000; k++) begin
      hold--;
      if (hold == 0) begin
        lvl = 1 - lvl;
        hold = int'($urandom_range(1, 4));
      end
      bm = ($urandom_range(0, 39) == 0);
      bi = ($urandom_range(0, 5) == 0);
      step(lvl[0], bm, bi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
